formula_n_isqrt_fsm: RTL



---
 rtl/formula_n_pkg.sv | 19 +
 rtl/formula_n_lane_tracker.sv | 28 ++
 rtl/formula_n_isqrt_fsm.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/formula_n_pkg.sv
// Shared types and batch-geometry helpers for the N-argument isqrt formula FSM.
package formula_n_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Number of lanes carrying an argument in batch k (the last batch may be short).
    function automatic int lanes_in_batch(input int k, input int n_args, input int n_isqrt);
        int rem;
        rem = n_args - k * n_isqrt;
        if (rem > n_isqrt) return n_isqrt;
        if (rem < 0) return 0;
        return rem;
    endfunction

endpackage

// File: rtl/formula_n_lane_tracker.sv
// Per-batch completion detect and root summation across the isqrt lanes.
module formula_n_lane_tracker #(
    parameter int N_ISQRT = 2,
    parameter int RW      = 16,
    parameter int RES_W   = 32
) (
    input  logic                           clr,
    input  logic [N_ISQRT-1:0]             used,
    input  logic [N_ISQRT-1:0]             flags,
    input  logic [N_ISQRT-1:0][RW-1:0]     hold,
    input  logic [N_ISQRT-1:0]             y_vld,
    input  logic [N_ISQRT-1:0][RW-1:0]     y,
    output logic                           all_done,
    output logic [RES_W-1:0]               sum
);

    always_comb begin
        all_done = ~clr;
        sum      = '0;
        for (int j = 0; j < N_ISQRT; j++) begin
            if (used[j] && !flags[j] && !y_vld[j]) all_done = 1'b0;
            // A flagged lane's root sits in hold; otherwise it is arriving this cycle.
            if (used[j] && (flags[j] || y_vld[j]))
                sum = sum + RES_W'(flags[j] ? hold[j] : y[j]);
        end
    end

endmodule

// File: rtl/formula_n_isqrt_fsm.sv
// res = sum of isqrt(arg[i]), arguments issued in batches over N_ISQRT external isqrt units.
// Define FORMULA_N_LAT_CNT_EN to add the lat_cycles latency counter output.
module formula_n_isqrt_fsm
    import formula_n_pkg::*;
#(
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2,
    parameter int ARG_W   = 32,
    parameter int RES_W   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arg_vld,
    output logic                           arg_rdy,
    input  logic [N_ARGS*ARG_W-1:0]        args,
    output logic                           res_vld,
    output logic [RES_W-1:0]               res,
`ifdef FORMULA_N_LAT_CNT_EN
    output logic [15:0]                    lat_cycles,
`endif
    output logic [N_ISQRT-1:0]             isqrt_x_vld,
    output logic [N_ISQRT*ARG_W-1:0]       isqrt_x,
    input  logic [N_ISQRT-1:0]             isqrt_y_vld,
    input  logic [N_ISQRT*(ARG_W/2)-1:0]   isqrt_y
);

    localparam int RW = ARG_W / 2;
    localparam int B  = ceil_div(N_ARGS, N_ISQRT);
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam logic [BW-1:0] LAST_BATCH = BW'(B - 1);

    state_e                        state_q, state_d;
    logic [N_ARGS*ARG_W-1:0]       args_q, args_d;
    logic [RES_W-1:0]              acc_q, acc_d;
    logic [RES_W-1:0]              res_q, res_d;
    logic                          res_vld_q, res_vld_d;
    logic [BW-1:0]                 batch_q, batch_d;
    logic [N_ISQRT-1:0]            flags_q, flags_d;
    logic [N_ISQRT-1:0][RW-1:0]    hold_q, hold_d;

    logic [N_ISQRT-1:0][RW-1:0]    y_lanes;
    logic [N_ISQRT-1:0]            used;
    logic                          all_done;
    logic [RES_W-1:0]              batch_sum;
    int                            n_cur;

    assign y_lanes = isqrt_y;
    assign arg_rdy = (state_q == IDLE);
    assign res     = res_q;
    assign res_vld = res_vld_q;

    always_comb begin
        used  = '0;
        n_cur = lanes_in_batch(int'(batch_q), N_ARGS, N_ISQRT);
        for (int j = 0; j < N_ISQRT; j++) used[j] = (j < n_cur);
    end

    formula_n_lane_tracker #(.N_ISQRT(N_ISQRT), .RW(RW), .RES_W(RES_W)) u_tracker (
        .clr      (state_q != WAIT),
        .used     (used),
        .flags    (flags_q),
        .hold     (hold_q),
        .y_vld    (isqrt_y_vld),
        .y        (y_lanes),
        .all_done (all_done),
        .sum      (batch_sum)
    );

    // Requests are a decode of ISSUE, so they last exactly one cycle per batch.
    always_comb begin
        isqrt_x_vld = '0;
        isqrt_x     = '0;
        if (state_q == ISSUE) begin
            for (int j = 0; j < N_ISQRT; j++) begin
                if (used[j]) begin
                    isqrt_x_vld[j]              = 1'b1;
                    isqrt_x[j*ARG_W +: ARG_W]   = args_q[(int'(batch_q)*N_ISQRT + j)*ARG_W +: ARG_W];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        args_d    = args_q;
        acc_d     = acc_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        batch_d   = batch_q;
        flags_d   = flags_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: if (arg_vld) begin
                args_d  = args;
                acc_d   = '0;
                batch_d = '0;
                flags_d = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                flags_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Only the first response on a used lane counts; repeats and strays are dropped.
                for (int j = 0; j < N_ISQRT; j++) begin
                    if (used[j] && isqrt_y_vld[j] && !flags_q[j]) begin
                        flags_d[j] = 1'b1;
                        hold_d[j]  = y_lanes[j];
                    end
                end
                if (all_done) begin
                    acc_d   = acc_q + batch_sum;
                    flags_d = '0;
                    if (batch_q == LAST_BATCH) begin
                        state_d = DONE;
                    end else begin
                        batch_d = batch_q + BW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                res_d     = acc_q;
                res_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            args_q    <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            batch_q   <= '0;
            flags_q   <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            args_q    <= args_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            batch_q   <= batch_d;
            flags_q   <= flags_d;
            hold_q    <= hold_d;
        end
    end

`ifdef FORMULA_N_LAT_CNT_EN
    logic [15:0] cnt_q, cnt_d, lat_q, lat_d, cnt_inc;

    assign cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign lat_cycles = lat_q;

    // Counts from the acceptance cycle, so lat_cycles equals acceptance-to-res_vld distance.
    always_comb begin
        cnt_d = cnt_q;
        lat_d = lat_q;
        case (state_q)
            IDLE:        if (arg_vld) cnt_d = 16'd1;
            ISSUE, WAIT: cnt_d = cnt_inc;
            DONE:        lat_d = cnt_inc;
            default:     cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lat_q <= lat_d;
        end
    end
`endif

endmodule
